dual_port_ram_be: RTL and testbench
===================================

Name: dual_port_ram_be

Overview:
- Parametrised successor to the team's single-port RAM.
- Adds a second, read-only port, per-lane byte enables, a selectable write mode on port A and a configurable read latency of 1 or 2.
- A hardware clear sequencer zeroes the array after reset or on request.
- Sits as a generic scratch/buffer memory between a producer (port A) and a consumer (port B).

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH
ADD_WIDTH, 4, address width in bits
DEPTH, 16, number of words; must be <= 2**ADD_WIDTH
LANE_WIDTH, 8, bits per byte-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH
READ_LATENCY, 1, cycles from accepted request to rvalid; legal values 1 or 2
WRITE_MODE, 0, port A write return data; 0 = read-first (old word), 1 = write-first (merged new word)
CLEAR_ON_RESET, 1, 1 = run the clear sequence when reset deasserts

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  one-cycle request to zero the whole array
busy  out  1  clear sequence in progress; port requests are ignored while high
a_en  in  1  port A request
a_we  in  1  port A write (1) or read (0)
a_be  in  NUM_LANES  port A lane write enables
a_addr  in  ADD_WIDTH  port A address
a_wdata  in  DATA_WIDTH  port A write data
a_rdata  out  DATA_WIDTH  port A return data
a_rvalid  out  1  a_rdata valid strobe
b_en  in  1  port B read request
b_addr  in  ADD_WIDTH  port B address
b_rdata  out  DATA_WIDTH  port B read data
b_rvalid  out  1  b_rdata valid strobe
collision  out  1  port B read hit a same-cycle port A write

Behaviour:
- Reset (reset=0), applied immediately:
  - a_rdata, b_rdata, a_rvalid, b_rvalid, collision and all pipeline stages go to 0.
  - busy goes to CLEAR_ON_RESET.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE; clear counter goes to 0.
  - Array contents are not reset asynchronously.
- FSM states:
  - IDLE: requests are serviced. clear=1 moves to CLEAR on the next edge; busy rises the cycle after clear is sampled.
  - CLEAR: writes 0 to word cnt each cycle, cnt runs 0..DEPTH-1 (DEPTH cycles total). After writing DEPTH-1 it returns to IDLE; busy is low the next cycle.
  - clear asserted while in CLEAR is ignored (no restart).
  - Reset asserted mid-clear aborts the sequence; it restarts at 0 if CLEAR_ON_RESET=1.
- While busy=1: a_en and b_en are ignored, no writes occur and no rvalid is generated. Requests already in the latency pipeline still complete.
- Port A request accepted when a_en=1 and busy=0:
  - a_we=1: each lane i with a_be[i]=1 is updated from a_wdata lane i; other lanes keep their value.
  - A write also returns data with a_rvalid: the old word when WRITE_MODE=0, the merged post-write word when WRITE_MODE=1.
  - a_we=0: returns mem[a_addr].
- Port B read accepted when b_en=1 and busy=0; always read-first, returns the pre-write word.
- collision: asserted together with b_rvalid when a B read and an A write with any a_be bit set target the same in-range address in the same cycle. a_be=0 is not a write for collision purposes.
- Latency:
  - READ_LATENCY=1: rdata/rvalid are registered at the edge that accepts the request.
  - READ_LATENCY=2: one further register stage; data, rvalid and collision shift together.
  - Back-to-back requests give one result per cycle, in order.
- rvalid is a one-cycle strobe per request. rdata holds its last value while rvalid=0.
- Address >= DEPTH: write dropped; read returns 0 with rvalid=1; never flags collision.
- Simultaneous A and B accesses to different addresses are independent.
- Simultaneous A writes and the clear FSM cannot occur (busy gating).

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=16 -> busy=1 for exactly 16 cycles. Afterwards, B reads of addr 0..15 all return 0x00 with b_rvalid one cycle after each request.
- A writes 0xA5 to addr 3 (a_be=1); next cycle B reads addr 3 -> b_rdata=0xA5, b_rvalid pulse at latency 1, collision=0.
- DATA_WIDTH=16, mem[5]=0x1234; A writes 0xABCD to addr 5 with a_be=2'b10 -> subsequent read returns 0xAB34. a_rdata on the write returns 0x1234 (WRITE_MODE=0) or 0xAB34 (WRITE_MODE=1).
- Same cycle: A writes 0x77 to addr 7 (old value 0x11) and B reads addr 7 -> b_rdata=0x11, collision=1 aligned with b_rvalid. Repeat with a_be=0 -> collision=0 and memory unchanged.
- READ_LATENCY=2: B reads addr 0,1,2 on consecutive cycles -> b_rvalid high on cycles 2,3,4 with data in order. Read of addr 20 with ADD_WIDTH=5, DEPTH=16 -> 0, rvalid=1.
- clear pulse mid-traffic, then re-pulse clear during busy -> single 16-cycle busy window and requests ignored. reset=0 on busy cycle 5 -> all outputs 0 at once; sequence restarts from addr 0 after release.

Source files
------------

// File: rtl/dual_port_ram_be.sv
// ============================================================================
// Module   : dual_port_ram_be
// Brief    : Dual-port RAM (A read/write, B read-only) with lane byte enables,
//            selectable write return mode, 1/2 cycle read latency, HW clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dual_port_ram_be #(
    parameter  int DATA_WIDTH     = 8,
    parameter  int ADD_WIDTH      = 4,
    parameter  int DEPTH          = 16,
    parameter  int LANE_WIDTH     = 8,
    parameter  int READ_LATENCY   = 1,
    parameter  int WRITE_MODE     = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [NUM_LANES-1:0]  a_be,
    input  logic [ADD_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic [ADD_WIDTH-1:0]  b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  collision
);

    localparam int                 IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADD_WIDTH:0] DEPTH_C  = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic [IDX_W-1:0]        cnt_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    a_acc;
    logic                    b_acc;
    logic                    a_in_range;
    logic                    b_in_range;
    logic [IDX_W-1:0]        a_idx;
    logic [IDX_W-1:0]        b_idx;
    logic                    a_wr;
    logic [DATA_WIDTH-1:0]   a_old;
    logic [DATA_WIDTH-1:0]   b_old;
    logic [DATA_WIDTH-1:0]   a_merged;
    logic [DATA_WIDTH-1:0]   a_rdata_d;
    logic                    collision_d;

    logic                    a_v1_q;
    logic                    b_v1_q;
    logic                    col1_q;
    logic [DATA_WIDTH-1:0]   a_d1_q;
    logic [DATA_WIDTH-1:0]   b_d1_q;

    // ------------------------------------------------------------------
    // Clear sequencer: sweeps every word once, then hands the array back.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            busy_q  <= (CLEAR_ON_RESET != 0);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    assign a_acc      = a_en & ~busy_q;
    assign b_acc      = b_en & ~busy_q;
    assign a_in_range = ({1'b0, a_addr} < DEPTH_C);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_C);
    assign a_idx      = a_addr[IDX_W-1:0];
    assign b_idx      = b_addr[IDX_W-1:0];
    assign a_wr       = a_acc & a_we & a_in_range;

    // Out-of-range addresses read as zero and never index the array.
    assign a_old = a_in_range ? mem_q[a_idx] : '0;
    assign b_old = b_in_range ? mem_q[b_idx] : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign a_merged[i*LANE_WIDTH +: LANE_WIDTH] =
            a_be[i] ? a_wdata[i*LANE_WIDTH +: LANE_WIDTH]
                    : a_old[i*LANE_WIDTH +: LANE_WIDTH];
    end

    assign a_rdata_d = (a_we && (WRITE_MODE != 0) && a_in_range) ? a_merged : a_old;

    // A write with no lane enabled changes nothing, so it cannot collide.
    assign collision_d = b_acc & a_acc & a_we & (|a_be) & a_in_range & b_in_range
                         & (a_addr == b_addr);

    always_ff @(posedge clk) begin
        if (busy_q) begin
            mem_q[cnt_q] <= '0;
        end else if (a_wr) begin
            mem_q[a_idx] <= a_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_v1_q <= 1'b0;
            b_v1_q <= 1'b0;
            col1_q <= 1'b0;
            a_d1_q <= '0;
            b_d1_q <= '0;
        end else begin
            a_v1_q <= a_acc;
            b_v1_q <= b_acc;
            col1_q <= collision_d;
            if (a_acc) begin
                a_d1_q <= a_rdata_d;
            end
            if (b_acc) begin
                b_d1_q <= b_old;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  a_v2_q;
        logic                  b_v2_q;
        logic                  col2_q;
        logic [DATA_WIDTH-1:0] a_d2_q;
        logic [DATA_WIDTH-1:0] b_d2_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_v2_q <= 1'b0;
                b_v2_q <= 1'b0;
                col2_q <= 1'b0;
                a_d2_q <= '0;
                b_d2_q <= '0;
            end else begin
                a_v2_q <= a_v1_q;
                b_v2_q <= b_v1_q;
                col2_q <= col1_q;
                if (a_v1_q) begin
                    a_d2_q <= a_d1_q;
                end
                if (b_v1_q) begin
                    b_d2_q <= b_d1_q;
                end
            end
        end

        assign a_rvalid  = a_v2_q;
        assign a_rdata   = a_d2_q;
        assign b_rvalid  = b_v2_q;
        assign b_rdata   = b_d2_q;
        assign collision = col2_q;
    end else begin : g_lat1
        assign a_rvalid  = a_v1_q;
        assign a_rdata   = a_d1_q;
        assign b_rvalid  = b_v1_q;
        assign b_rdata   = b_d1_q;
        assign collision = col1_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_be.sv
// ============================================================================
// Module   : tb_dual_port_ram_be
// Brief    : Directed bench for dual_port_ram_be over three configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dual_port_ram_be;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    // u0: 8-bit, latency 1, read-first
    logic       a_en0 = 0, a_we0 = 0, b_en0 = 0;
    logic [0:0] a_be0 = 0;
    logic [3:0] a_addr0 = 0, b_addr0 = 0;
    logic [7:0] a_wdata0 = 0;
    logic [7:0] a_rdata0, b_rdata0;
    logic       a_rvalid0, b_rvalid0, collision0, busy0;

    // u1: 16-bit, two lanes, write-first
    logic        a_en1 = 0, a_we1 = 0, b_en1 = 0;
    logic [1:0]  a_be1 = 0;
    logic [3:0]  a_addr1 = 0, b_addr1 = 0;
    logic [15:0] a_wdata1 = 0;
    logic [15:0] a_rdata1, b_rdata1;
    logic        a_rvalid1, b_rvalid1, collision1, busy1;

    // u2: 5-bit address over 16 words, latency 2
    logic       a_en2 = 0, a_we2 = 0, b_en2 = 0;
    logic [0:0] a_be2 = 0;
    logic [4:0] a_addr2 = 0, b_addr2 = 0;
    logic [7:0] a_wdata2 = 0;
    logic [7:0] a_rdata2, b_rdata2;
    logic       a_rvalid2, b_rvalid2, collision2, busy2;

    dual_port_ram_be u0 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy0),
        .a_en(a_en0), .a_we(a_we0), .a_be(a_be0), .a_addr(a_addr0),
        .a_wdata(a_wdata0), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en0), .b_addr(b_addr0), .b_rdata(b_rdata0),
        .b_rvalid(b_rvalid0), .collision(collision0)
    );

    dual_port_ram_be #(.DATA_WIDTH(16), .WRITE_MODE(1)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy1),
        .a_en(a_en1), .a_we(a_we1), .a_be(a_be1), .a_addr(a_addr1),
        .a_wdata(a_wdata1), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en1), .b_addr(b_addr1), .b_rdata(b_rdata1),
        .b_rvalid(b_rvalid1), .collision(collision1)
    );

    dual_port_ram_be #(.ADD_WIDTH(5), .DEPTH(16), .READ_LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy2),
        .a_en(a_en2), .a_we(a_we2), .a_be(a_be2), .a_addr(a_addr2),
        .a_wdata(a_wdata2), .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
        .b_en(b_en2), .b_addr(b_addr2), .b_rdata(b_rdata2),
        .b_rvalid(b_rvalid2), .collision(collision2)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int rv;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   busy0,      1);
        check("rst_busy2",  busy2,      1);
        check("rst_arv",    a_rvalid0,  0);
        check("rst_brv",    b_rvalid0,  0);
        check("rst_brdata", b_rdata0,   0);
        check("rst_col",    collision0, 0);

        // Clear after reset release lasts DEPTH cycles
        reset = 1'b1;
        measure_busy(n);
        check("rst_clear_len", n, 16);

        for (int i = 0; i < 16; i++) begin
            b_en0 = 1; b_addr0 = i[3:0];
            tick();
            check("clr_rvalid", b_rvalid0, 1);
            check("clr_rdata",  b_rdata0,  0);
        end
        b_en0 = 0;
        tick();
        check("rvalid_strobe", b_rvalid0, 0);

        // Write then read back
        a_en0 = 1; a_we0 = 1; a_be0 = 1; a_addr0 = 3; a_wdata0 = 8'hA5;
        tick();
        check("wr_arvalid", a_rvalid0, 1);
        check("wr_old",     a_rdata0,  8'h00);
        a_en0 = 0; b_en0 = 1; b_addr0 = 3;
        tick();
        check("rd3_data", b_rdata0,   8'hA5);
        check("rd3_rv",   b_rvalid0,  1);
        check("rd3_col",  collision0, 0);
        check("rd3_arv",  a_rvalid0,  0);

        // Collision: same-address A write and B read
        b_en0 = 0; a_en0 = 1; a_addr0 = 7; a_wdata0 = 8'h11;
        tick();
        a_wdata0 = 8'h77; b_en0 = 1; b_addr0 = 7;
        tick();
        check("col_bdata", b_rdata0,   8'h11);
        check("col_flag",  collision0, 1);
        check("col_brv",   b_rvalid0,  1);
        check("col_adata", a_rdata0,   8'h11);
        a_en0 = 0; b_en0 = 0;
        tick();
        check("col_clr",   collision0, 0);
        check("idle_brv",  b_rvalid0,  0);
        check("hold_data", b_rdata0,   8'h11);

        // a_be=0 write: no collision, memory untouched
        a_en0 = 1; a_be0 = 0; a_wdata0 = 8'h99; b_en0 = 1;
        tick();
        check("be0_col",   collision0, 0);
        check("be0_bdata", b_rdata0,   8'h77);
        a_en0 = 0;
        tick();
        check("be0_unchanged", b_rdata0, 8'h77);

        // Different addresses in the same cycle
        a_en0 = 1; a_be0 = 1; a_addr0 = 8; a_wdata0 = 8'h42; b_addr0 = 3;
        tick();
        check("indep_bdata", b_rdata0,   8'hA5);
        check("indep_col",   collision0, 0);
        a_en0 = 0; b_addr0 = 8;
        tick();
        check("indep_rd8", b_rdata0, 8'h42);
        b_en0 = 0;

        // Port A plain read
        a_en0 = 1; a_we0 = 0; a_addr0 = 7;
        tick();
        check("ard_data", a_rdata0,  8'h77);
        check("ard_rv",   a_rvalid0, 1);
        a_en0 = 0;
        tick();

        // Lane enables, write-first return
        a_en1 = 1; a_we1 = 1; a_be1 = 2'b11; a_addr1 = 5; a_wdata1 = 16'h1234;
        tick();
        check("wm1_full", a_rdata1, 16'h1234);
        a_be1 = 2'b10; a_wdata1 = 16'hABCD;
        tick();
        check("wm1_merge", a_rdata1,  16'hAB34);
        check("wm1_rv",    a_rvalid1, 1);
        a_en1 = 0; b_en1 = 1; b_addr1 = 5;
        tick();
        check("lane_rd", b_rdata1, 16'hAB34);
        b_en1 = 0;

        // Latency 2 pipeline ordering
        a_en2 = 1; a_we2 = 1; a_be2 = 1;
        a_addr2 = 0; a_wdata2 = 8'h10; tick();
        a_addr2 = 1; a_wdata2 = 8'h21; tick();
        a_addr2 = 2; a_wdata2 = 8'h32; tick();
        a_en2 = 0;
        tick();
        tick();
        b_en2 = 1; b_addr2 = 0;
        tick();
        check("l2_c1_rv", b_rvalid2, 0);
        b_addr2 = 1;
        tick();
        check("l2_c2_rv", b_rvalid2, 1);
        check("l2_c2_d",  b_rdata2,  8'h10);
        b_addr2 = 2;
        tick();
        check("l2_c3_rv", b_rvalid2, 1);
        check("l2_c3_d",  b_rdata2,  8'h21);
        b_en2 = 0;
        tick();
        check("l2_c4_rv", b_rvalid2, 1);
        check("l2_c4_d",  b_rdata2,  8'h32);
        tick();
        check("l2_c5_rv", b_rvalid2, 0);

        // Out-of-range write/read on the wide-address instance
        a_en2 = 1; a_we2 = 1; a_be2 = 1; a_addr2 = 20; a_wdata2 = 8'hEE;
        b_en2 = 1; b_addr2 = 20;
        tick();
        a_en2 = 0; b_en2 = 0;
        check("oor_rv_early", b_rvalid2, 0);
        tick();
        check("oor_brv",   b_rvalid2,  1);
        check("oor_bdata", b_rdata2,   8'h00);
        check("oor_col",   collision2, 0);
        check("oor_arv",   a_rvalid2,  1);
        check("oor_adata", a_rdata2,   8'h00);
        b_en2 = 1; b_addr2 = 1;
        tick();
        b_addr2 = 4;
        tick();
        b_en2 = 0;
        check("alias_prev", b_rdata2, 8'h21);
        tick();
        check("alias_rd4", b_rdata2, 8'h00);

        // Clear mid-traffic; re-pulse during busy is ignored
        b_en0 = 1; b_addr0 = 3; clear = 1;
        tick();
        check("clr_req_served", b_rdata0, 8'hA5);
        check("clr_busy_rise",  busy0,    1);
        clear = 0;
        a_en0 = 1; a_we0 = 1; a_be0 = 1; a_addr0 = 3; a_wdata0 = 8'h55;
        n = 1; rv = 0;
        while (busy0 && n < 40) begin
            if (n == 3) clear = 1;
            if (n == 5) clear = 0;
            tick();
            if (a_rvalid0 || b_rvalid0) rv++;
            if (busy0) n++;
        end
        a_en0 = 0; b_en0 = 0; clear = 0;
        check("clr_len",     n,  16);
        check("clr_ignored", rv, 0);
        b_en0 = 1; b_addr0 = 3;
        tick();
        check("clr_rd3", b_rdata0,  8'h00);
        check("clr_rv3", b_rvalid0, 1);
        b_en0 = 0;

        // Reset during a clear sweep
        a_en0 = 1; a_we0 = 1; a_addr0 = 3; a_wdata0 = 8'h5A; tick();
        a_addr0 = 15; a_wdata0 = 8'hF0; tick();
        a_we0 = 0; a_addr0 = 3; b_en0 = 1; b_addr0 = 15; clear = 1;
        tick();
        check("pre_rst_a", a_rdata0, 8'h5A);
        check("pre_rst_b", b_rdata0, 8'hF0);
        clear = 0; a_en0 = 0; b_en0 = 0;
        repeat (4) tick();
        check("busy_c5", busy0, 1);
        reset = 0;
        #1;
        check("mid_rst_adata", a_rdata0,  8'h00);
        check("mid_rst_bdata", b_rdata0,  8'h00);
        check("mid_rst_busy",  busy0,     1);
        check("mid_rst_brv",   b_rvalid0, 0);
        tick();
        tick();
        reset = 1;
        measure_busy(n);
        check("restart_len", n, 16);
        b_en0 = 1; b_addr0 = 3;
        tick();
        check("restart_rd3", b_rdata0, 8'h00);
        b_addr0 = 15;
        tick();
        check("restart_rd15", b_rdata0, 8'h00);
        b_en0 = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
